// File: rtl/uart_frame_rx_pkg.sv
// Shared types and constants for the uart_frame_rx serial frame receiver.
// Optional parity support is selected with the UART_FRAME_RX_PARITY_EN macro.
package uart_frame_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int ST_NONEMPTY  = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVR       = 2;
    localparam int ST_FERR      = 3;
    localparam int ST_PERR      = 4;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_COUNT_W   = 3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

`ifdef UART_FRAME_RX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Serial bits per frame for the standard 16-bit link word.
    localparam int FRAME_LEN = 1 + 16 + PARITY_BITS + 1;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received words; reading while empty yields zero.
// A pop frees a slot in the same cycle, so push into a full FIFO succeeds when paired with a pop.
module uart_rx_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Serial frame receiver: start bit, DATA_W bits MSB first, optional parity, stop bit.
// Parity is enabled by defining UART_FRAME_RX_PARITY_EN; words land in a FIFO read over the register bus.
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int BIT_CYCLES = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic [1:0]  Address_u,
    input  logic        r,
    input  logic        w,
    input  logic [15:0] Data_in_u,
    output logic [15:0] Data_out_u,
    output logic        irq
);

    localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0] FULL_LOAD = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'((BIT_CYCLES - 1) / 2);

    logic rx_meta;
    logic rxs;
    logic rxd;

    rx_state_t         state;
    logic [TW-1:0]     timer;
    logic [IW-1:0]     bit_idx;
    logic [DATA_W-1:0] shift;
    logic              frame_perr;
    logic              tick;

    logic              ctrl_en;
    logic              ctrl_irq_en;
    logic              ovr;
    logic              ferr;
    logic              perr;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              pop;
    logic              push;
    logic              stop_hit;
    logic              ovr_set;
    logic              ferr_set;
    logic              perr_set;
    logic [2:0]        sclr;
    logic [15:0]       status_word;
    logic [15:0]       rd_value;
    logic              unused_data_in;

    // The start edge is detected on rxs while bits are sampled on rxd, one stage later,
    // so START can still re-check a start bit that lasts a single clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxd     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxd     <= rxs;
        end
    end

    assign tick     = (timer == '0);
    assign pop      = r && (Address_u == ADDR_DATA) && !fifo_empty;
    assign stop_hit = ctrl_en && (state == STOP) && tick;
    assign push     = stop_hit && rxd && !frame_perr && (!fifo_full || pop);
    assign ovr_set  = stop_hit && rxd && !frame_perr && fifo_full && !pop;
    assign ferr_set = stop_hit && !rxd;

`ifdef UART_FRAME_RX_PARITY_EN
    logic par_bad;
    assign par_bad  = ^{shift, rxd};
    assign perr_set = ctrl_en && (state == PARITY) && tick && par_bad;
`else
    assign perr_set = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            frame_perr <= 1'b0;
        end else if (!ctrl_en) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            timer <= tick ? FULL_LOAD : timer - 1'b1;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state      <= START;
                        timer      <= HALF_LOAD;
                        frame_perr <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rxd) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= IW'(DATA_W - 1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift <= {shift[DATA_W-2:0], rxd};
                        if (bit_idx == '0) begin
`ifdef UART_FRAME_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                        end
                    end
                end
`ifdef UART_FRAME_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        frame_perr <= par_bad;
                        state      <= STOP;
                    end
                end
`else
                PARITY: state <= IDLE;
`endif
                STOP: begin
                    if (tick) begin
                        // A start bit may already be on rxs when the stop bit is sampled
                        // on back-to-back frames at one clock per bit.
                        if (!rxd) begin
                            state <= WAIT_HIGH;
                        end else if (!rxs) begin
                            state      <= START;
                            timer      <= HALF_LOAD;
                            frame_perr <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rxd) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign sclr = (w && !r && (Address_u == ADDR_STATUS)) ? Data_in_u[ST_PERR:ST_OVR] : 3'b000;
    assign unused_data_in = ^{Data_in_u[15:5]};

    // The count field is three bits wide; a full depth-8 FIFO is identified by the full bit.
    always_comb begin
        status_word = '0;
        status_word[ST_NONEMPTY] = !fifo_empty;
        status_word[ST_FULL]     = fifo_full;
        status_word[ST_OVR]      = ovr;
        status_word[ST_FERR]     = ferr;
        status_word[ST_PERR]     = perr;
        status_word[ST_COUNT_LSB +: ST_COUNT_W] = 3'(fifo_count);
    end

    always_comb begin
        rd_value = '0;
        case (Address_u)
            ADDR_DATA:   rd_value = 16'(fifo_head);
            ADDR_STATUS: rd_value = status_word;
            ADDR_CTRL:   rd_value = {14'b0, ctrl_irq_en, ctrl_en};
            ADDR_RSVD:   rd_value = '0;
            default:     rd_value = '0;
        endcase
    end

    // Sticky flags: a set event in the same cycle as a clear write wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ovr         <= 1'b0;
            ferr        <= 1'b0;
            perr        <= 1'b0;
            Data_out_u  <= '0;
            irq         <= 1'b0;
        end else begin
            ovr  <= ovr_set  | (ovr  & ~sclr[0]);
            ferr <= ferr_set | (ferr & ~sclr[1]);
            perr <= perr_set | (perr & ~sclr[2]);
            irq  <= ctrl_irq_en & !fifo_empty;
            if (r) begin
                Data_out_u <= rd_value;
            end else if (w && (Address_u == ADDR_CTRL)) begin
                ctrl_en     <= Data_in_u[CTRL_EN];
                ctrl_irq_en <= Data_in_u[CTRL_IRQ_EN];
            end
        end
    end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
Standalone serial frame receiver, the decoding end of the team's 16-bit UART link. It deserialises frames of 1 start bit (0), DATA_W data bits MSB first, an optional parity bit and 1 stop bit (1). Received words are buffered in a small FIFO. The block has the same register-mapped r/w/address bus style as the existing UART, so a CPU-side bus master polls it or takes an interrupt.

Parameters:
DATA_W, 16, data bits per frame
BIT_CYCLES, 1, clocks per serial bit (>=1; 1 matches the existing one-bit-per-clock transmitter)
FIFO_DEPTH, 4, received-word buffer depth (power of 2, 2..8)

Ports:
clk  in  1  system clock; only clock domain
reset  in  1  synchronous, active-high reset
rx  in  1  serial input, asynchronous, idles high
Address_u  in  2  register select
r  in  1  read strobe, one-cycle pulse
w  in  1  write strobe, one-cycle pulse; r has priority if both are high
Data_in_u  in  16  write data
Data_out_u  out  16  registered read data, valid the cycle after r
irq  out  1  registered interrupt = CTRL.irq_en & status.nonempty

Behaviour:
- Single clock; reset is synchronous and active-high. Reset clears all state, FIFO empty, sticky flags clear, CTRL=0 (receiver disabled), Data_out_u=0, irq=0. Reset mid-frame discards the frame.
- rx passes through a 2-flop synchroniser, reset value 1. All sampling uses the synchronised rxs.
- Bit timer: counter reloads to BIT_CYCLES-1 and decrements each clock. "Tick" = counter==0. Half-bit load = (BIT_CYCLES-1)/2.
- FSM states and transitions:
  - IDLE: if CTRL.en and rxs==0, go to START and load the half-bit count.
  - START: on tick, re-check rxs. If 1, it is a false start: go to IDLE. If 0, go to DATA with bit index DATA_W-1 and a full-bit reload.
  - DATA: on each tick, shift rxs into the shift register MSB first. After bit 0, go to PARITY (macro defined) or STOP.
  - STOP: on tick, sample rxs.
    - rxs==1, FIFO not full and no parity error: push the word.
    - rxs==1, FIFO full: set OVR sticky, drop the word.
    - rxs==0: set FERR sticky, drop the word, go to WAIT_HIGH.
    - Otherwise return to IDLE.
  - WAIT_HIGH: stay until rxs==1, then go to IDLE. This handles a break.
- CTRL.en cleared mid-frame: abort to IDLE on the next clock, with no push and no flags set.
- Register map:
  - 0 DATA: r pops the FIFO head into Data_out_u. Pop when empty returns 0 and changes nothing. w is ignored.
  - 1 STATUS read:
    - bit0 nonempty, bit1 full
    - bit2 OVR, bit3 FERR, bit4 PERR (0 without the macro)
    - bits[10:8] count, other bits 0
  - 1 STATUS write: writing 1 clears the matching bit[4:2]; other bits are ignored.
  - 2 CTRL: read/write. bit0 en, bit1 irq_en, other bits read 0.
  - 3: reads 0, writes ignored.
- Push and pop in the same cycle: both take effect and count is unchanged. Pop of a full FIFO plus push in the same cycle succeeds with no overrun.
- A sticky-set event coincident with a clear write: the set wins.
- Latency: the word is readable in STATUS the cycle after the stop-bit tick.

Optional Feature:
UART_FRAME_RX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA. One bit is sampled on tick, and even parity over data+parity is expected. A mismatch sets PERR sticky and drops the word at STOP.
- Undefined: no parity bit, the frame is 18 bits, and PERR reads 0.

Decomposition:
- Package uart_frame_rx_pkg holds:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  - register address constants
  - STATUS/CTRL bit indices
  - frame-length constant
- One sub-module, uart_rx_fifo: synchronous FIFO with push/pop/full/empty/count and read-when-empty returning 0. The FSM, synchroniser and register decode stay in the top.

Test Plan:
- Enable (write CTRL=1), send frame 0xA5C3, BIT_CYCLES=1 -> STATUS=0x0101; read DATA returns 0xA5C3, then STATUS=0x0000.
- BIT_CYCLES=4, 1-clock low glitch on rx -> no push, FSM returns to IDLE, STATUS=0.
- Send 5 frames 0x0001..0x0005 with depth 4 and no reads -> count=4, full=1, OVR=1; reads return 0x0001..0x0004; write STATUS 0x0004 clears OVR.
- Frame 0x1234 with stop bit 0, rx held low 10 clocks -> FERR=1, no push, next valid frame 0x5678 is received only after rx returns high.
- CTRL=3, frame 0xFFFF -> irq=1 the cycle after push; pop -> irq=0 the next cycle. Assert reset mid-frame -> all outputs 0 and FIFO empty.
- Macro defined: frame 0x0003 with parity 1 -> PERR=1 and no push; with parity 0 -> word received, PERR unchanged.
